moore_seq_gen: RTL and testbench
================================

// Module: moore_seq_gen
// PURPOSE
//  Moore-style serial pattern transmitter: emits a fixed PAT_W-bit pattern (default 11011), MSB first,
//  one bit per clock, repeated repeat_n times per start request.
//  Transmit-side companion of the team's serial sequence detectors; drives detector 'in' pins in
//  system loopback and self-test paths. All outputs come from registered state only (Moore).
// PARAMETERS
//  PAT_W    5         pattern length in bits (>=2)
//  PATTERN  5'b11011  pattern; bit PAT_W-1 is transmitted first
//  OVL_LEN  2         pattern suffix==prefix overlap length (0..PAT_W-1); used only with OVERLAP_EN
//  CNT_W    4         width of repeat count
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  repeat_n   in   CNT_W  repetitions; captured on accepted start
//  abort      in   1      synchronous abort of an active transfer
//  out        out  1      serial bit (0 when out_valid=0)
//  out_valid  out  1      out carries a pattern bit this cycle
//  busy       out  1      transfer in progress (SHIFT or DONE)
//  done       out  1      one-cycle pulse after the last bit of a completed transfer
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; out=0, out_valid=0, busy=0, done=0; counters=0.
//  - States: IDLE, SHIFT, DONE.
//  - IDLE: start=1 at edge N, repeat_n!=0 -> SHIFT; capture repeat_n; bit idx=PAT_W-1.
//    After edge N: out=PATTERN[PAT_W-1], out_valid=1, busy=1 (zero-cycle request-to-first-bit latency after the edge).
//  - IDLE: start=1, repeat_n==0 -> DONE directly; no bit is emitted; done pulses for one cycle.
//  - SHIFT: each edge decrements idx. At idx==0: decrement the remaining count.
//    remaining>1 -> reload idx (see CONFIGURATION) and stay in SHIFT; else go to DONE.
//  - DONE: done=1, busy=1, out_valid=0, out=0 for exactly one cycle, then IDLE.
//  - start while busy is ignored; it is not queued. start in the DONE cycle is also ignored.
//  - abort=1 in SHIFT: next edge -> IDLE with all outputs 0 and no done pulse.
//    abort in IDLE or DONE has no effect; DONE still completes.
//  - repeat_n is sampled only at acceptance; later changes are ignored.
//    Max transfer = 2^CNT_W-1 repetitions.
//  - Bit stream is continuous: no idle cycle between repetitions.
//  - Outputs must be registered; no combinational path from any input to any output.
// CONFIGURATION
//  OVERLAP_EN defined: the first repetition emits all PAT_W bits.
//    Each later repetition emits only PAT_W-OVL_LEN bits: idx reloads to PAT_W-OVL_LEN-1,
//    and the shared OVL_LEN prefix is not re-sent. An overlapping detector sees exactly repeat_n matches.
//    Total bits = PAT_W + (R-1)*(PAT_W-OVL_LEN).
//  OVERLAP_EN undefined: every repetition emits the full PAT_W bits, idx reloads to PAT_W-1,
//    and OVL_LEN is unused. Total bits = R*PAT_W.
// STRUCTURE
//  - Package moore_seq_pkg:
//    - state enum (IDLE/SHIFT/DONE);
//    - default PAT_W/PATTERN/OVL_LEN constants, shared with the detector benches;
//    - function computing total bit count for given R.
//  - One natural sub-module, seq_shift_reg: loadable bit-index/pattern selector.
//    Inputs: load value, decrement enable. Outputs: current bit, last-bit flag.
//  - The top level holds the FSM, repeat counter and output registers.
// TESTING
//  - Reset mid-SHIFT (assert rst between edges, bit 3 of a transfer):
//    out/out_valid/busy fall immediately without a clock; after release the next start behaves normally.
//  - start=1, repeat_n=1:
//    out=1,1,0,1,1 with out_valid=1 on 5 cycles; done=1 on 6th cycle; busy=1 for 6 cycles.
//  - start=1, repeat_n=2, OVERLAP_EN undefined: stream 1101111011 (10 bits), then done.
//    With OVERLAP_EN: stream 11011011 (8 bits), then done.
//    A loopback overlapping 11011 detector counts 2 matches in both cases.
//  - start=1, repeat_n=0: no out_valid; done=1 the cycle after acceptance; busy=1 for that one cycle.
//  - abort on 3rd bit of repeat_n=3: IDLE next edge, done never asserts.
//    start held high throughout a transfer starts no second transfer until IDLE.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared types and default constants for the Moore serial
// pattern transmitter and the sequence-detector benches that pair with it.
//   state_e     : transmitter FSM state encoding
//   *_DEF       : default pattern length / pattern / overlap / count width
//   total_bits(): number of serial bits emitted for a transfer of r repetitions
// Build option: OVERLAP_EN (later repetitions skip the shared overlap prefix).
package moore_seq_pkg;

  localparam int unsigned PAT_W_DEF   = 5;
  localparam logic [4:0]  PATTERN_DEF = 5'b11011;
  localparam int unsigned OVL_LEN_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 4;

`ifdef OVERLAP_EN
  localparam bit OVERLAP_ON = 1'b1;
`else
  localparam bit OVERLAP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int unsigned total_bits(input int unsigned r,
                                             input int unsigned pat_w,
                                             input int unsigned ovl_len);
    int unsigned skip;
    skip = OVERLAP_ON ? ovl_len : 0;
    if (r == 0) return 0;
    return pat_w + (r - 1) * (pat_w - skip);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: loadable bit index into a fixed pattern with a registered
// bit output, so the selected pattern bit is available straight from a flop.
//   clk, rst      : clock, async active-high reset
//   load_i        : load load_val_i into the index (has priority over dec_i)
//   load_val_i    : index value to load
//   dec_i         : decrement the index
//   bit_o         : pattern bit at the current index (registered)
//   last_o        : current index is 0 (last bit of the pattern)
module seq_shift_reg
  import moore_seq_pkg::*;
#(
  parameter int unsigned       PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0]  PATTERN = PATTERN_DEF,
  parameter int unsigned       IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             bit_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bit_q, bit_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i)     idx_d = load_val_i;
    else if (dec_i) idx_d = idx_q - IDX_W'(1);
    // Pre-select the bit for the next index so bit_o is a flop output.
    bit_d = PATTERN[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      bit_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      bit_q <= bit_d;
    end
  end

  assign bit_o  = bit_q;
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/moore_seq_gen.sv
// moore_seq_gen: Moore serial pattern transmitter. Sends PATTERN MSB first,
// one bit per clock, repeat_n times per accepted start, then a one-cycle done.
//   clk, rst   : clock, async active-high reset
//   start      : transfer request, sampled only in IDLE
//   repeat_n   : repetition count, captured when start is accepted
//   abort      : synchronous abort of a transfer in SHIFT
//   out        : serial bit (0 when out_valid is low)
//   out_valid  : out carries a pattern bit
//   busy       : SHIFT or DONE
//   done       : one-cycle pulse after the last bit of a completed transfer
// Build option: OVERLAP_EN -- repetitions after the first omit the OVL_LEN-bit
// prefix that overlaps the previous pattern's suffix.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | emitting pattern bits
// ST_DONE  | one-cycle completion pulse
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned      OVL_LEN = OVL_LEN_DEF,
  parameter int unsigned      CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W     = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(PAT_W - 1);
`ifdef OVERLAP_EN
  localparam logic [IDX_W-1:0] IDX_RELOAD = IDX_W'(PAT_W - OVL_LEN - 1);
`else
  localparam logic [IDX_W-1:0] IDX_RELOAD = IDX_FIRST;
`endif

  if (PAT_W < 2) begin : g_chk_pat_w
    $error("moore_seq_gen: PAT_W must be at least 2");
  end
  if (OVL_LEN >= PAT_W) begin : g_chk_ovl_len
    $error("moore_seq_gen: OVL_LEN must be below PAT_W");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load, sr_dec, sr_bit, sr_last;
  logic [IDX_W-1:0] sr_load_val;

  seq_shift_reg #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .IDX_W   (IDX_W)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sr_load),
    .load_val_i (sr_load_val),
    .dec_i      (sr_dec),
    .bit_o      (sr_bit),
    .last_o     (sr_last)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sr_load     = 1'b0;
    sr_load_val = IDX_FIRST;
    sr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            state_d = ST_SHIFT;
            rem_d   = repeat_n;
            sr_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (sr_last) begin
          if (rem_q > CNT_W'(1)) begin
            // Next repetition follows with no gap.
            rem_d       = rem_q - CNT_W'(1);
            sr_load     = 1'b1;
            sr_load_val = IDX_RELOAD;
          end else begin
            rem_d   = '0;
            state_d = ST_DONE;
          end
        end else begin
          sr_dec = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Flag outputs are decoded from the next state and registered.
    out_valid_d = (state_d == ST_SHIFT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // AND of two flops: out is forced low whenever no pattern bit is on the line.
  assign out       = out_valid_q & sr_bit;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
module tb_moore_seq_gen;

  localparam int         PW  = 5;
  localparam logic [4:0] PAT = 5'b11011;
  localparam int         OVL = 2;
`ifdef OVERLAP_EN
  localparam bit OVL_ON = 1'b1;
`else
  localparam bit OVL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] repeat_n = 4'd0;
  logic       out, out_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {out, out_valid, busy, done} per cycle, pushed when stimulus is driven.
  logic [3:0] exp_q[$];

  moore_seq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .repeat_n  (repeat_n),
    .abort     (abort),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Loopback overlapping detector for the pattern.
  logic       det_clr = 1'b0;
  logic [4:0] det_hist = 5'd0;
  int         det_len = 0;
  int         det_cnt = 0;
  always @(negedge clk) begin
    if (det_clr) begin
      det_hist = 5'd0;
      det_len  = 0;
      det_cnt  = 0;
    end else if (out_valid) begin
      det_hist = {det_hist[3:0], out};
      if (det_len < PW) det_len++;
      if (det_len >= PW && det_hist == PAT) det_cnt++;
    end
  end

  task automatic push_xfer(input int r);
    logic [4:0] p;
    int top;
    p = PAT;
    for (int k = 0; k < r; k++) begin
      top = (k > 0 && OVL_ON) ? PW - OVL - 1 : PW - 1;
      for (int b = top; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
    end
    exp_q.push_back(4'b0011);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(4'b0000);
  endtask

  task automatic launch(input int r, input bit hold);
    @(negedge clk);
    start    = 1'b1;
    repeat_n = 4'(r);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    repeat_n = 4'hF;
  endtask

  task automatic det_reset();
    det_clr = 1'b1;
    @(negedge clk);
    #1 det_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    #1 rst = 1'b1;
    #2;
    got = {out, out_valid, busy, done};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_hold got=%b exp=0000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {out, out_valid, busy, done};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_idle got=%b exp=0000", got);
    end
  endtask

  task automatic test_single();
    logic [3:0] got, e;
    int i;
    push_xfer(1);
    push_idle(1);
    launch(1, 1'b0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL single cyc%0d got=%b exp=%b", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_repeat2();
    logic [3:0] got, e;
    int i;
    det_reset();
    push_xfer(2);
    push_idle(1);
    launch(2, 1'b0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL repeat2 cyc%0d got=%b exp=%b", i, got, e);
      end
      i++;
    end
    @(negedge clk);
    n_cmp++;
    if (det_cnt !== 2) begin
      n_bad++;
      $display("FAIL repeat2_detect got=%0d exp=2", det_cnt);
    end
  endtask

  task automatic test_zero();
    logic [3:0] got, e;
    int i;
    push_xfer(0);
    push_idle(2);
    launch(0, 1'b0);
    abort = 1'b1;  // abort during DONE must not cancel the pulse
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL zero cyc%0d got=%b exp=%b", i, got, e);
      end
      if (i == 0) abort = 1'b0;
      i++;
    end
  endtask

  task automatic test_abort();
    logic [3:0] got, e;
    int i;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    push_idle(4);
    launch(3, 1'b0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL abort cyc%0d got=%b exp=%b", i, got, e);
      end
      if (i == 2) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0] got, e;
    int i;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    launch(1, 1'b0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL rst_mid cyc%0d got=%b exp=%b", i, got, e);
      end
      i++;
    end
    #2 rst = 1'b1;
    #1;
    got = {out, out_valid, busy, done};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid_async got=%b exp=0000", got);
    end
    #1 rst = 1'b0;
    test_single();
  endtask

  task automatic test_start_held();
    logic [3:0] got, e;
    int i;
    push_xfer(1);
    push_idle(1);
    push_xfer(2);
    push_idle(2);
    launch(1, 1'b1);
    repeat_n = 4'd2;  // picked up only by the next accepted start
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = {out, out_valid, busy, done};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL start_held cyc%0d got=%b exp=%b", i, got, e);
      end
      if (i == 6) begin
        @(posedge clk);
        #1 start = 1'b0;
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat2();
    test_zero();
    test_abort();
    test_reset_mid_shift();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
